operand_stack: RTL and testbench
================================

OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, minimum 2.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-high; clock clk.
REQ-005 push  input  1  write push_data onto stack this cycle.
REQ-006 push_data  input  WIDTH  word to push.
REQ-007 pop  input  1  remove top entry this cycle.
REQ-008 clr_err  input  1  clear sticky error flags.
REQ-009 tos  output  WIDTH  current top-of-stack word, combinational from storage; 0 when empty.
REQ-010 pop_data  output  WIDTH  registered word removed by the last accepted pop.
REQ-011 pop_valid  output  1  one-cycle pulse, pop_data updated this cycle.
REQ-012 count  output  log2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 full  output  1  count == DEPTH.
REQ-015 overflow  output  1  sticky, a push was rejected.
REQ-016 underflow  output  1  sticky, a pop was rejected.

Function
REQ-017 All state updates occur on the rising clk edge; empty/full/tos derive combinationally from count and storage.
REQ-018 Push only, not full: entry[count] <= push_data, count +1, tos = push_data next cycle.
REQ-019 Push only, full: storage and count unchanged, overflow <= 1.
REQ-020 Pop only, not empty: pop_data <= old tos, pop_valid <= 1 for exactly the next cycle, count -1.
REQ-021 Pop only, empty: count unchanged, pop_data unchanged, pop_valid stays 0, underflow <= 1.
REQ-022 Push and pop, not empty (including full): replace top; pop_data <= old tos, pop_valid <= 1, top entry <= push_data, count unchanged, no overflow.
REQ-023 Push and pop, empty: treated as push only; underflow <= 1, pop_valid stays 0, count becomes 1.
REQ-024 pop_valid is 0 in every cycle not following an accepted pop; back-to-back pops produce back-to-back pulses.
REQ-025 pop_data holds its value until the next accepted pop.
REQ-026 Entries at index >= count are don't-care and never visible on tos or pop_data.
REQ-027 clr_err clears overflow and underflow next cycle; a new error event in the same cycle wins (flag stays 1).
REQ-028 count arithmetic never wraps: never exceeds DEPTH, never below 0.

Reset
REQ-029 On rst high, immediately and without clk: count=0, empty=1, full=0, tos=0, pop_data=0, pop_valid=0, overflow=0, underflow=0.
REQ-030 Storage contents need not be cleared; they are unobservable while empty.
REQ-031 rst asserted mid-operation (including during a pop_valid cycle) forces the reset values above; push/pop in the cycle rst deasserts are honoured normally at the next edge.

Verification
REQ-032 Reset, push 0x11,0x22,0x33 -> count=3, tos=0x33; pop -> next cycle pop_valid=1, pop_data=0x33, tos=0x22, count=2.
REQ-033 Push 16 words 0x00..0x0F, then push 0xAA -> full=1, count=16, tos=0x0F, overflow=1; clr_err -> overflow=0.
REQ-034 From empty, pop -> pop_valid=0, underflow=1, count=0; push+pop together with push_data=0x5C -> count=1, tos=0x5C, pop_valid=0.
REQ-035 Full stack (tos=0x0F), push+pop with push_data=0x77 -> pop_data=0x0F, pop_valid=1, tos=0x77, count=16, overflow=0.
REQ-036 Stack with count=2, pop two consecutive cycles -> two consecutive pop_valid pulses, data in LIFO order, then empty=1.
REQ-037 Assert rst asynchronously between edges while count=5 and overflow=1 -> count=0, empty=1, overflow=0, pop_valid=0 before the next clk edge.

Source files
------------

// File: rtl/operand_stack_if.sv
// -----------------------------------------------------------------------------
// operand_stack_if
// Signal bundle between an operand stack and its user.
//   master : the user; drives push/push_data/pop/clr_err and observes status.
//   slave  : the stack; observes the commands and drives the status outputs.
// Signals:
//   push, push_data  - push request and the word to push
//   pop              - pop request
//   clr_err          - clear the sticky overflow/underflow flags
//   tos              - current top of stack (0 when empty)
//   pop_data         - word removed by the last accepted pop
//   pop_valid        - one-cycle pulse, pop_data updated this cycle
//   count            - number of valid entries, 0..DEPTH
//   empty, full      - occupancy flags
//   overflow         - sticky, a push was rejected
//   underflow        - sticky, a pop was rejected
// -----------------------------------------------------------------------------
interface operand_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic             clr_err;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, push_data, pop, clr_err,
    input  tos, pop_data, pop_valid, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, push_data, pop, clr_err,
    output tos, pop_data, pop_valid, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/operand_stack.sv
// -----------------------------------------------------------------------------
// operand_stack
// LIFO operand stack of DEPTH words of WIDTH bits with a registered pop port,
// top-of-stack replace (push+pop in one cycle) and sticky error flags.
// Ports:
//   clk  - rising-edge clock for all state
//   rst  - asynchronous, active-high reset
//   bus  - operand_stack_if.slave: push/push_data/pop/clr_err in;
//          tos/pop_data/pop_valid/count/empty/full/overflow/underflow out
// tos, empty and full are combinational from count and storage; everything
// else is registered. Storage is not reset; entries at index >= count are
// never visible because tos is forced to zero when empty and only the entry
// below count is ever read.
// -----------------------------------------------------------------------------
module operand_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  operand_stack_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_pop_data;
  logic             r_pop_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic [AW-1:0]    w_top_idx;
  logic [WIDTH-1:0] w_tos;
  logic             w_wr_en;
  logic [AW-1:0]    w_wr_idx;
  logic             w_pop_acc;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic [CW-1:0]    w_count_nxt;

  // Occupancy flags and top-of-stack read.
  // When full, count's low AW bits are 0, so subtracting 1 wraps to DEPTH-1,
  // which is exactly the top entry.
  always_comb begin
    w_empty   = (r_count == CW'(0));
    w_full    = (r_count == CW'(DEPTH));
    w_top_idx = r_count[AW-1:0] - AW'(1);
    if (w_empty) begin
      w_tos = WIDTH'(0);
    end else begin
      w_tos = r_mem[w_top_idx];
    end
  end

  // Command decode: write enable/index, accepted pop, error events, next count.
  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_idx    = r_count[AW-1:0];
    w_pop_acc   = 1'b0;
    w_ovf_evt   = 1'b0;
    w_unf_evt   = 1'b0;
    w_count_nxt = r_count;
    case ({bus.push, bus.pop})
      2'b10: begin
        if (w_full) begin
          w_ovf_evt = 1'b1;
        end else begin
          w_wr_en     = 1'b1;
          w_count_nxt = r_count + CW'(1);
        end
      end
      2'b01: begin
        if (w_empty) begin
          w_unf_evt = 1'b1;
        end else begin
          w_pop_acc   = 1'b1;
          w_count_nxt = r_count - CW'(1);
        end
      end
      2'b11: begin
        if (w_empty) begin
          // Nothing to pop: behaves as a plain push into slot 0.
          w_unf_evt   = 1'b1;
          w_wr_en     = 1'b1;
          w_count_nxt = CW'(1);
        end else begin
          // Replace top in place; count unchanged, never overflows.
          w_pop_acc = 1'b1;
          w_wr_en   = 1'b1;
          w_wr_idx  = w_top_idx;
        end
      end
      default: begin
        w_wr_en = 1'b0;
      end
    endcase
  end

  // Storage write; contents are intentionally left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= bus.push_data;
    end
  end

  // Count, pop port and sticky error flags.
  // A new error event takes priority over clr_err in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= CW'(0);
      r_pop_data  <= WIDTH'(0);
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_pop_valid <= w_pop_acc;
      if (w_pop_acc) begin
        r_pop_data <= w_tos;
      end
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_unf_evt) begin
        r_underflow <= 1'b1;
      end else if (bus.clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign bus.tos       = w_tos;
  assign bus.pop_data  = r_pop_data;
  assign bus.pop_valid = r_pop_valid;
  assign bus.count     = r_count;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_operand_stack.sv
// -----------------------------------------------------------------------------
// tb_operand_stack
// Directed bench for operand_stack (WIDTH=8, DEPTH=16) with hand-computed
// expected values. Inputs change on the falling edge; outputs are sampled
// 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_operand_stack;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  operand_stack_if #(.WIDTH(8), .DEPTH(16)) bus ();

  operand_stack #(.WIDTH(8), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // Single comparison point for every check.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; returns 1 time unit after the rising edge.
  task automatic drive(input logic pu, input logic [7:0] d, input logic po, input logic cl);
    @(negedge clk);
    bus.push      = pu;
    bus.push_data = d;
    bus.pop       = po;
    bus.clr_err   = cl;
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.push      = 1'b0;
    bus.push_data = 8'h00;
    bus.pop       = 1'b0;
    bus.clr_err   = 1'b0;

    // Reset state
    #12;
    check_eq("rst_count",  32'(bus.count),     32'd0);
    check_eq("rst_empty",  32'(bus.empty),     32'd1);
    check_eq("rst_full",   32'(bus.full),      32'd0);
    check_eq("rst_tos",    32'(bus.tos),       32'h00);
    check_eq("rst_pdata",  32'(bus.pop_data),  32'h00);
    check_eq("rst_pvalid", 32'(bus.pop_valid), 32'd0);
    check_eq("rst_ovf",    32'(bus.overflow),  32'd0);
    check_eq("rst_unf",    32'(bus.underflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic push/pop
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    check_eq("p3_count", 32'(bus.count), 32'd3);
    check_eq("p3_tos",   32'(bus.tos),   32'h33);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("pop_pvalid", 32'(bus.pop_valid), 32'd1);
    check_eq("pop_pdata",  32'(bus.pop_data),  32'h33);
    check_eq("pop_tos",    32'(bus.tos),       32'h22);
    check_eq("pop_count",  32'(bus.count),     32'd2);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("idle_pvalid", 32'(bus.pop_valid), 32'd0);
    check_eq("idle_pdata",  32'(bus.pop_data),  32'h33);

    // Back-to-back pops from count=2
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("b2b1_pvalid", 32'(bus.pop_valid), 32'd1);
    check_eq("b2b1_pdata",  32'(bus.pop_data),  32'h22);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("b2b2_pvalid", 32'(bus.pop_valid), 32'd1);
    check_eq("b2b2_pdata",  32'(bus.pop_data),  32'h11);
    check_eq("b2b2_empty",  32'(bus.empty),     32'd1);
    check_eq("b2b2_tos",    32'(bus.tos),       32'h00);

    // Underflow and push+pop on empty
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("unf_pvalid", 32'(bus.pop_valid), 32'd0);
    check_eq("unf_flag",   32'(bus.underflow), 32'd1);
    check_eq("unf_count",  32'(bus.count),     32'd0);
    check_eq("unf_pdata",  32'(bus.pop_data),  32'h11);
    drive(1'b1, 8'h5C, 1'b1, 1'b0);
    check_eq("pp_empty_count",  32'(bus.count),     32'd1);
    check_eq("pp_empty_tos",    32'(bus.tos),       32'h5C);
    check_eq("pp_empty_pvalid", 32'(bus.pop_valid), 32'd0);
    check_eq("pp_empty_unf",    32'(bus.underflow), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("clr_unf", 32'(bus.underflow), 32'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("pop5c_pdata", 32'(bus.pop_data), 32'h5C);
    check_eq("pop5c_count", 32'(bus.count),    32'd0);
    // Error event in the same cycle as clr_err keeps the flag set
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("unf_vs_clr", 32'(bus.underflow), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("unf_clr2", 32'(bus.underflow), 32'd0);

    // Fill to full, then overflow
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
    end
    check_eq("fill_count", 32'(bus.count),    32'd16);
    check_eq("fill_full",  32'(bus.full),     32'd1);
    check_eq("fill_tos",   32'(bus.tos),      32'h0F);
    check_eq("fill_ovf",   32'(bus.overflow), 32'd0);
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    check_eq("ovf_full",  32'(bus.full),     32'd1);
    check_eq("ovf_count", 32'(bus.count),    32'd16);
    check_eq("ovf_tos",   32'(bus.tos),      32'h0F);
    check_eq("ovf_flag",  32'(bus.overflow), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("clr_ovf", 32'(bus.overflow), 32'd0);

    // Replace top while full
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    check_eq("rep_pdata",  32'(bus.pop_data),  32'h0F);
    check_eq("rep_pvalid", 32'(bus.pop_valid), 32'd1);
    check_eq("rep_tos",    32'(bus.tos),       32'h77);
    check_eq("rep_count",  32'(bus.count),     32'd16);
    check_eq("rep_ovf",    32'(bus.overflow),  32'd0);

    // Set overflow again, then drain to count=5 checking LIFO order
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    check_eq("ovf2_flag", 32'(bus.overflow), 32'd1);
    check_eq("ovf2_tos",  32'(bus.tos),      32'h77);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("drain_first", 32'(bus.pop_data), 32'h77);
    for (int i = 14; i >= 5; i--) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      check_eq("drain_pdata", 32'(bus.pop_data), 32'(i));
    end
    check_eq("drain_count",  32'(bus.count),     32'd5);
    check_eq("drain_tos",    32'(bus.tos),       32'h04);
    check_eq("drain_ovf",    32'(bus.overflow),  32'd1);
    check_eq("drain_pvalid", 32'(bus.pop_valid), 32'd1);

    // Asynchronous reset between edges, during a pop_valid cycle
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_count",  32'(bus.count),     32'd0);
    check_eq("arst_empty",  32'(bus.empty),     32'd1);
    check_eq("arst_ovf",    32'(bus.overflow),  32'd0);
    check_eq("arst_pvalid", 32'(bus.pop_valid), 32'd0);
    check_eq("arst_pdata",  32'(bus.pop_data),  32'h00);
    check_eq("arst_tos",    32'(bus.tos),       32'h00);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    check_eq("post_rst_count", 32'(bus.count), 32'd1);
    check_eq("post_rst_tos",   32'(bus.tos),   32'h99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
